// File: rtl/multiword_adder_seq_pkg.sv
// Shared definitions for the multiword adder sequencer: state encoding and clog2.
package multiword_adder_seq_pkg;

  // Encoding 3 is unused; the FSM returns to IDLE if it ever decodes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/multiword_adder_seq_ripple_add_slice.sv
// SIZE-bit gate-level ripple-carry adder slice, purely combinational.
module ripple_add_slice #(
  parameter int SIZE = 4
) (
  output wire             co,
  output wire [SIZE-1:0]  sum,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  input  logic            ci
);

  wire [SIZE:0]   c;
  wire [SIZE-1:0] p;
  wire [SIZE-1:0] g;
  wire [SIZE-1:0] t;

  assign c[0] = ci;

  for (genvar i = 0; i < SIZE; i++) begin : g_bit
    xor u_p   (p[i],   a[i], b[i]);
    xor u_s   (sum[i], p[i], c[i]);
    and u_g   (g[i],   a[i], b[i]);
    and u_t   (t[i],   p[i], c[i]);
    or  u_c   (c[i+1], g[i], t[i]);
  end

  assign co = c[SIZE];

endmodule

// File: rtl/multiword_adder_seq.sv
// Adds two WORDS*SIZE-bit operands through one shared SIZE-bit slice, LSW first.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one slice word per cycle, idx selects the word
// DONE  | result presented, held until out_ready
module multiword_adder_seq
  import multiword_adder_seq_pkg::*;
#(
  parameter  int SIZE  = 4,
  parameter  int WORDS = 4,
  localparam int W     = SIZE * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         ovf,
  output logic         busy
);

  localparam int IDXW = (clog2(WORDS) > 1) ? clog2(WORDS) : 1;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [W-1:0]      a_q, b_q;
  logic [W-1:0]      sum_q;
  logic              co_q, ovf_q;

  logic [SIZE-1:0]   slice_a, slice_b;
  wire  [SIZE-1:0]   slice_sum;
  wire               slice_co;
  logic              last_word;

  assign slice_a   = a_q[idx_q*SIZE +: SIZE];
  assign slice_b   = b_q[idx_q*SIZE +: SIZE];
  assign last_word = (idx_q == IDXW'(WORDS - 1));

  ripple_add_slice #(.SIZE(SIZE)) u_slice (
    .co  (slice_co),
    .sum (slice_sum),
    .a   (slice_a),
    .b   (slice_b),
    .ci  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= ci;
            idx_q   <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          sum_q[idx_q*SIZE +: SIZE] <= slice_sum;
          carry_q                   <= slice_co;
          if (last_word) begin
            co_q  <= slice_co;
            ovf_q <= (a_q[W-1] == b_q[W-1]) && (slice_sum[SIZE-1] != a_q[W-1]);
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Scoreboard bench: a 4x4-bit instance and a 1x8-bit instance against an arithmetic model.
module tb_multiword_adder_seq;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ovf;
    int          cyc;
  } exp_a_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ovf;
    int         cyc;
  } exp_b_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic        iv_a = 1'b0, ci_a = 1'b0, ir_a, ov_a, or_a, co_a, ovf_a, busy_a;
  logic [15:0] a_a = '0, b_a = '0, sum_a;
  logic        iv_b = 1'b0, ci_b = 1'b0, ir_b, ov_b, or_b, co_b, ovf_b, busy_b;
  logic [7:0]  a_b = '0, b_b = '0, sum_b;

  logic rdy_rand_a = 1'b0, rdy_fix_a = 1'b1, rnd_a = 1'b0;
  logic rdy_rand_b = 1'b0, rdy_fix_b = 1'b1, rnd_b = 1'b0;
  logic prev_ov_a = 1'b0, prev_ov_b = 1'b0;
  logic btb_b = 1'b0;
  int   last_acc_b = -1;

  exp_a_t qa[$];
  exp_b_t qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    rnd_a <= 1'($urandom_range(0, 1));
    rnd_b <= 1'($urandom_range(0, 1));
  end
  assign or_a = rdy_rand_a ? rnd_a : rdy_fix_a;
  assign or_b = rdy_rand_b ? rnd_b : rdy_fix_b;

  multiword_adder_seq #(.SIZE(4), .WORDS(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .a(a_a), .b(b_a), .ci(ci_a),
    .out_valid(ov_a), .out_ready(or_a), .sum(sum_a), .co(co_a), .ovf(ovf_a), .busy(busy_a));

  multiword_adder_seq #(.SIZE(8), .WORDS(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .a(a_b), .b(b_b), .ci(ci_b),
    .out_valid(ov_b), .out_ready(or_b), .sum(sum_b), .co(co_b), .ovf(ovf_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the full-width values.
  function automatic exp_a_t model_a(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_a_t e;
    int u, s;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    e.s   = u[15:0];
    e.co  = (u > 65535);
    e.ovf = (s > 32767) || (s < -32768);
    e.cyc = 0;
    return e;
  endfunction

  function automatic exp_b_t model_b(input logic [7:0] x, input logic [7:0] y, input logic c);
    exp_b_t e;
    int u, s;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    e.s   = u[7:0];
    e.co  = (u > 255);
    e.ovf = (s > 127) || (s < -128);
    e.cyc = 0;
    return e;
  endfunction

  // Accept detection: an accept happens at the next rising edge.
  always @(negedge clk) begin
    exp_a_t ea;
    exp_b_t eb;
    if (rst) begin
      qa.delete();
      qb.delete();
      last_acc_b = -1;
    end else begin
      if (iv_a && ir_a) begin
        ea = model_a(a_a, b_a, ci_a);
        ea.cyc = cyc + 1;
        qa.push_back(ea);
      end
      if (iv_b && ir_b) begin
        eb = model_b(a_b, b_b, ci_b);
        eb.cyc = cyc + 1;
        qb.push_back(eb);
        if (btb_b && last_acc_b >= 0) chk("b_initiation_interval", cyc + 1 - last_acc_b, 3);
        last_acc_b = cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_a_t e;
    if (!rst && ov_a) begin
      if (qa.size() == 0) chk("a_spurious_out_valid", 1, 0);
      else begin
        e = qa[0];
        chk("a_sum", sum_a, e.s);
        chk("a_co", co_a, e.co);
        chk("a_ovf", ovf_a, e.ovf);
        chk("a_in_ready_in_done", {ir_a, busy_a}, 2'b01);
        if (!prev_ov_a) chk("a_latency", cyc - e.cyc, 4);
        if (or_a) void'(qa.pop_front());
      end
    end
    prev_ov_a = ov_a;
  end

  always @(negedge clk) begin
    exp_b_t e;
    if (!rst && ov_b) begin
      if (qb.size() == 0) chk("b_spurious_out_valid", 1, 0);
      else begin
        e = qb[0];
        chk("b_sum", sum_b, e.s);
        chk("b_co", co_b, e.co);
        chk("b_ovf", ovf_b, e.ovf);
        if (!prev_ov_b) chk("b_latency", cyc - e.cyc, 1);
        if (or_b) void'(qb.pop_front());
      end
    end
    prev_ov_b = ov_b;
  end

  // Drivers are entered 1 time unit after a rising edge and return at the same phase.
  task automatic send_a(input logic [15:0] x, input logic [15:0] y, input logic c);
    int n = 0;
    a_a = x; b_a = y; ci_a = c; iv_a = 1'b1;
    @(negedge clk);
    while (!ir_a && n < 200) begin @(negedge clk); n++; end
    if (!ir_a) chk("a_accept_timeout", 1, 0);
    @(posedge clk); #1;
    iv_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] x, input logic [7:0] y, input logic c);
    int n = 0;
    a_b = x; b_b = y; ci_b = c; iv_b = 1'b1;
    @(negedge clk);
    while (!ir_b && n < 200) begin @(negedge clk); n++; end
    if (!ir_b) chk("b_accept_timeout", 1, 0);
    @(posedge clk); #1;
    iv_b = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || !ir_a || !ir_b) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", n < 2000, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with requests pending: nothing may be accepted.
    iv_a = 1'b1; a_a = 16'h1111; b_a = 16'h2222;
    iv_b = 1'b1; a_b = 8'h33;   b_b = 8'h44;
    repeat (2) begin
      @(negedge clk);
      chk("rst_a_flags", {ir_a, ov_a, busy_a, co_a, ovf_a}, 5'b10000);
      chk("rst_a_sum", sum_a, 0);
      chk("rst_b_flags", {ir_b, ov_b, busy_b, co_b, ovf_b}, 5'b10000);
      chk("rst_b_sum", sum_b, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; iv_a = 1'b0; iv_b = 1'b0;

    send_a(16'hFFFF, 16'h0001, 1'b0);
    send_a(16'h7FFF, 16'h0001, 1'b0);
    send_a(16'h1234, 16'h4321, 1'b1);
    drain();

    // Backpressure with competing requests while DONE is held.
    rdy_fix_a = 1'b0;
    send_a(16'h8001, 16'h8002, 1'b1);
    for (int n = 0; n < 20 && !ov_a; n++) begin @(posedge clk); #1; end
    chk("a_reached_done", ov_a, 1);
    for (int k = 0; k < 10; k++) begin
      iv_a = 1'b1; a_a = 16'($urandom); b_a = 16'($urandom); ci_a = 1'($urandom);
      @(posedge clk); #1;
    end
    iv_a = 1'b0;
    rdy_fix_a = 1'b1;
    @(negedge clk);
    chk("a_bp_before_release", {ir_a, ov_a}, 2'b01);
    @(negedge clk);
    chk("a_bp_after_release", {ir_a, ov_a}, 2'b10);
    @(posedge clk); #1;

    // Reset while idx=2 in RUN.
    send_a(16'hABCD, 16'h5432, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("a_mid_run_reset", {ir_a, ov_a}, 2'b10);
    chk("a_mid_run_reset_sum", sum_a, 0);
    @(posedge clk); #1;
    send_a(16'h00F0, 16'h0F10, 1'b0);
    drain();

    rdy_rand_a = 1'b1;
    for (int k = 0; k < 150; k++) begin
      send_a(16'($urandom), 16'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    drain();
    rdy_rand_a = 1'b0;

    // Single-word instance: directed case, then back-to-back at the minimum interval.
    send_b(8'h80, 8'h80, 1'b0);
    drain();
    btb_b = 1'b1;
    for (int k = 0; k < 20; k++) send_b(8'($urandom), 8'($urandom), 1'($urandom));
    drain();
    btb_b = 1'b0;
    rdy_rand_b = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send_b(8'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();

    chk("a_queue_empty", qa.size(), 0);
    chk("b_queue_empty", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
